// File: rtl/ft232h_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ft232h_tx_arbiter
// Brief   : Packet-granular round-robin arbiter sharing the FT232H TX stream
//           among NUM_SRC byte sources, with a mid-packet stall watchdog.
//           Define FT232H_ARB_HEADER_EN to prefix each packet with {4'hA, id}.
// Rev     : 1.0  initial release
// ============================================================================
module ft232h_tx_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int STALL_CYCLES = 1024
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [NUM_SRC*8-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]   s_tvalid,
    input  logic [NUM_SRC-1:0]   s_tlast,
    output logic [NUM_SRC-1:0]   s_tready,
    output logic [7:0]           m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [3:0]           grant_id,
    output logic                 busy,
    output logic                 stall_err
);
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int WD_W  = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] c_wd_last   = WD_W'((STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0);
    localparam logic [3:0]      c_last_init = 4'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    state_t          r_state;
    logic [7:0]      r_m_tdata;
    logic            r_m_tvalid;
    logic [3:0]      r_grant_id;
    logic [3:0]      r_last_grant;
    logic            r_stall_err;
    logic [WD_W-1:0] r_wd_cnt;

    logic             w_free;
    logic             w_in_pkt;
    logic [IDX_W-1:0] w_gsel;
    logic             w_valid_g;
    logic             w_last_g;
    logic [7:0]       w_byte_g;
    logic             w_xfer;
    logic             w_found;
    logic [3:0]       w_pick;
    logic [4:0]       w_idx;

    assign w_free    = !r_m_tvalid || m_tready;
    assign w_in_pkt  = (r_state == ST_HEADER) || (r_state == ST_DATA);
    assign w_gsel    = r_grant_id[IDX_W-1:0];
    assign w_valid_g = s_tvalid[w_gsel];
    assign w_last_g  = s_tlast[w_gsel];
    assign w_byte_g  = s_tdata[{w_gsel, 3'b000} +: 8];
    assign w_xfer    = w_in_pkt && w_valid_g && w_free;

    always_comb begin
        s_tready = '0;
        if (w_in_pkt && w_free) begin
            s_tready[w_gsel] = 1'b1;
        end
    end

    // Round-robin search from last_grant+1; last_grant itself is tried last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 4'd0;
        w_idx   = 5'd0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_idx = {1'b0, r_last_grant} + 5'(k);
            if (w_idx >= 5'(NUM_SRC)) begin
                w_idx = w_idx - 5'(NUM_SRC);
            end
            if (!w_found && s_tvalid[w_idx[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[3:0];
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state      <= ST_IDLE;
            r_m_tdata    <= 8'h00;
            r_m_tvalid   <= 1'b0;
            r_grant_id   <= 4'd0;
            r_last_grant <= c_last_init;
            r_stall_err  <= 1'b0;
            r_wd_cnt     <= '0;
        end else begin
            r_stall_err <= 1'b0;
            if (w_free) begin
                r_m_tvalid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_found && w_free) begin
                        r_grant_id <= w_pick;
                        r_wd_cnt   <= '0;
`ifdef FT232H_ARB_HEADER_EN
                        r_m_tdata  <= {4'hA, w_pick};
                        r_m_tvalid <= 1'b1;
                        r_state    <= ST_HEADER;
`else
                        r_state    <= ST_DATA;
`endif
                    end
                end
                // HEADER already accepts payload so the first byte follows the header directly.
                ST_HEADER, ST_DATA: begin
                    if (w_xfer) begin
                        r_m_tdata  <= w_byte_g;
                        r_m_tvalid <= 1'b1;
                        r_wd_cnt   <= '0;
                        if (w_last_g) begin
                            r_last_grant <= r_grant_id;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end else if (r_state == ST_HEADER) begin
                        r_state <= ST_DATA;
                    end else if (!w_valid_g && (STALL_CYCLES != 0)) begin
                        if (r_wd_cnt == c_wd_last) begin
                            r_stall_err  <= 1'b1;
                            r_last_grant <= r_grant_id;
                            r_wd_cnt     <= '0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_wd_cnt <= r_wd_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_tdata   = r_m_tdata;
    assign m_tvalid  = r_m_tvalid;
    assign grant_id  = r_grant_id;
    assign busy      = w_in_pkt;
    assign stall_err = r_stall_err;

endmodule
`default_nettype wire

// File: tb/tb_ft232h_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ft232h_tx_arbiter
// Brief   : Scoreboard bench for ft232h_tx_arbiter (NUM_SRC=4, STALL_CYCLES=8);
//           expectations follow FT232H_ARB_HEADER_EN when it is defined.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ft232h_tx_arbiter;
    localparam int NSRC  = 4;
    localparam int STALL = 8;
`ifdef FT232H_ARB_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic              sys_clk  = 1'b0;
    logic              sys_rst  = 1'b1;
    logic              m_tready = 1'b1;
    logic [NSRC*8-1:0] s_tdata  = '0;
    logic [NSRC-1:0]   s_tvalid = '0;
    logic [NSRC-1:0]   s_tlast  = '0;
    logic [NSRC-1:0]   s_tready;
    logic [7:0]        m_tdata;
    logic              m_tvalid;
    logic [3:0]        grant_id;
    logic              busy;
    logic              stall_err;

    ft232h_tx_arbiter #(
        .NUM_SRC      (NSRC),
        .STALL_CYCLES (STALL)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .grant_id  (grant_id),
        .busy      (busy),
        .stall_err (stall_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge sys_clk) cyc++;

    logic [8:0] src_mem [NSRC][64];
    int         src_wr [NSRC];
    int         src_rd [NSRC];
    bit         acc    [NSRC];

    logic [7:0] exp_q[$];
    int         rec_cyc[$];
    logic       rec_busy[$];
    logic [3:0] rec_gid[$];
    logic [7:0] rec_dat[$];
    int         stall_cyc[$];
    logic       stall_busy[$];
    bit         mon_en    = 1'b1;
    bit         prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input int src, input int n, input logic [7:0] base,
                            input bit with_last, input bit expect_it);
        logic [7:0] b;
        logic [3:0] id;
        id = 4'(src);
`ifdef FT232H_ARB_HEADER_EN
        if (expect_it) exp_q.push_back({4'hA, id});
`endif
        for (int j = 0; j < n; j++) begin
            b = base + 8'(j);
            src_mem[src][src_wr[src]] = {(with_last && (j == n - 1)), b};
            src_wr[src]++;
            if (expect_it) exp_q.push_back(b);
        end
    endtask

    task automatic clear_rec();
        rec_cyc.delete();
        rec_busy.delete();
        rec_gid.delete();
        rec_dat.delete();
        stall_cyc.delete();
        stall_busy.delete();
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!(exp_q.size() == 0 && !busy && !m_tvalid) && n < 300);
        check({name, " completion"}, 32'(exp_q.size() == 0 && !busy && !m_tvalid), 32'd1);
        @(negedge sys_clk);
    endtask

    // Source models: advance on the handshake seen before the edge, then present the next byte.
    always @(posedge sys_clk) begin
        #1;
        for (int i = 0; i < NSRC; i++) begin
            if (acc[i] && src_rd[i] < src_wr[i]) src_rd[i]++;
            if (src_rd[i] < src_wr[i]) begin
                s_tvalid[i]        = 1'b1;
                s_tdata[i*8 +: 8]  = src_mem[i][src_rd[i]][7:0];
                s_tlast[i]         = src_mem[i][src_rd[i]][8];
            end else begin
                s_tvalid[i]        = 1'b0;
                s_tdata[i*8 +: 8]  = 8'h00;
                s_tlast[i]         = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge sys_clk) begin
        logic [7:0] e;
        for (int i = 0; i < NSRC; i++) acc[i] = s_tvalid[i] && s_tready[i];
        if (sys_rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("held valid", 32'(m_tvalid), 32'd1);
                check("held data", 32'(m_tdata), 32'(prev_data));
            end
            prev_hold = m_tvalid && !m_tready;
            prev_data = m_tdata;
            if (stall_err) begin
                stall_cyc.push_back(cyc);
                stall_busy.push_back(busy);
            end
            if (mon_en && m_tvalid && m_tready) begin
                rec_cyc.push_back(cyc);
                rec_busy.push_back(busy);
                rec_gid.push_back(grant_id);
                rec_dat.push_back(m_tdata);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wire byte: got %02h, expected nothing", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wire byte", 32'(m_tdata), 32'(e));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int gaps2, gapsbad, d, c60, n;
        for (int i = 0; i < NSRC; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
            acc[i]    = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge sys_clk);
        check("rst m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst m_tdata", 32'(m_tdata), 32'h00);
        check("rst s_tready", 32'(s_tready), 32'd0);
        check("rst grant_id", 32'(grant_id), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst stall_err", 32'(stall_err), 32'd0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Round robin 0,1,3,0 from reset, headers A0/A1/A3/A0, no gaps with header
        clear_rec();
        push_pkt(0, 2, 8'h20, 1, 1);
        push_pkt(1, 2, 8'h30, 1, 1);
        push_pkt(3, 2, 8'h50, 1, 1);
        push_pkt(0, 2, 8'h22, 1, 1);
        wait_done("rr");
        check("rr byte count", 32'(rec_cyc.size()), (HDR != 0) ? 32'd12 : 32'd8);
        if (rec_cyc.size() > 0)
            check("rr span", 32'(rec_cyc[rec_cyc.size()-1] - rec_cyc[0]), (HDR != 0) ? 32'd11 : 32'd10);
        gaps2 = 0;
        gapsbad = 0;
        for (int j = 1; j < rec_cyc.size(); j++) begin
            d = rec_cyc[j] - rec_cyc[j-1];
            if (d == 2) gaps2++;
            else if (d != 1) gapsbad++;
        end
        check("rr bubbles", 32'(gaps2), (HDR != 0) ? 32'd0 : 32'd3);
        check("rr long gaps", 32'(gapsbad), 32'd0);

        // Single packet from source 2
        clear_rec();
        push_pkt(2, 3, 8'h10, 1, 1);
        wait_done("src2");
        check("src2 byte count", 32'(rec_cyc.size()), (HDR != 0) ? 32'd4 : 32'd3);
        if (rec_cyc.size() > 1) begin
            check("src2 span", 32'(rec_cyc[rec_cyc.size()-1] - rec_cyc[0]), (HDR != 0) ? 32'd3 : 32'd2);
            check("src2 busy first", 32'(rec_busy[0]), 32'd1);
            check("src2 busy at tlast", 32'(rec_busy[rec_busy.size()-1]), 32'd0);
        end
        check("src2 grant_id", 32'(grant_id), 32'd2);

        // Watchdog: source 1 stalls after one byte, source 2 pending
        clear_rec();
        push_pkt(1, 1, 8'h60, 0, 1);
        push_pkt(2, 1, 8'h70, 1, 1);
        wait_done("stall");
        c60 = -100;
        for (int j = 0; j < rec_dat.size(); j++) if (rec_dat[j] == 8'h60) c60 = rec_cyc[j];
        check("stall pulse count", 32'(stall_cyc.size()), 32'd1);
        if (stall_cyc.size() > 0) begin
            check("stall pulse cycle", 32'(stall_cyc[0] - c60), 32'd8);
            check("stall back to idle", 32'(stall_busy[0]), 32'd0);
        end
        check("stall next grant", 32'(grant_id), 32'd2);

        // m_tready 1,0,0,1 during a packet from source 0
        clear_rec();
        push_pkt(0, 3, 8'h40, 1, 1);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!m_tvalid && n < 50);
        check("tready start", 32'(m_tvalid), 32'd1);
        @(posedge sys_clk); #1 m_tready = 1'b1;
        @(negedge sys_clk);
        @(posedge sys_clk); #1 m_tready = 1'b0;
        @(negedge sys_clk);
        check("tready blocked valid", 32'(m_tvalid), 32'd1);
        check("tready blocked data", 32'(m_tdata), (HDR != 0) ? 32'h41 : 32'h42);
        check("tready blocked s_tready", 32'(s_tready), 32'd0);
        @(posedge sys_clk); #1 m_tready = 1'b0;
        @(negedge sys_clk);
        check("tready held data", 32'(m_tdata), (HDR != 0) ? 32'h41 : 32'h42);
        check("tready held s_tready", 32'(s_tready), 32'd0);
        @(posedge sys_clk); #1 m_tready = 1'b1;
        wait_done("tready");
        check("tready byte count", 32'(rec_cyc.size()), (HDR != 0) ? 32'd4 : 32'd3);

        // Asynchronous reset mid-packet from source 3
        clear_rec();
        mon_en = 1'b0;
        push_pkt(3, 4, 8'hB0, 1, 0);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!(busy && m_tvalid) && n < 50);
        @(negedge sys_clk);
        check("midrst grant before", 32'(grant_id), 32'd3);
        #2 sys_rst = 1'b1;
        #1;
        check("midrst m_tvalid", 32'(m_tvalid), 32'd0);
        check("midrst s_tready", 32'(s_tready), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst grant_id", 32'(grant_id), 32'd0);
        for (int i = 0; i < NSRC; i++) src_rd[i] = src_wr[i];
        exp_q.delete();
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        mon_en  = 1'b1;
        clear_rec();
        push_pkt(0, 1, 8'h80, 1, 1);
        push_pkt(1, 1, 8'h90, 1, 1);
        wait_done("post reset");
        if (rec_gid.size() > 0) check("post reset first grant", 32'(rec_gid[0]), 32'd0);
        check("post reset byte count", 32'(rec_cyc.size()), (HDR != 0) ? 32'd4 : 32'd2);

        repeat (3) @(negedge sys_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
